// File: rtl/fifo_axis_master.sv
// fifo_axis_master: drains an FWFT synchronous FIFO into an AXI4-Stream master.
// A two-entry buffer (head + skid) decouples FIFO pops from m_axis_tready, so
// o_fifo_rd depends only on registered occupancy. A beat counter frames the
// stream into BURST_LEN-beat packets with tlast on the final beat.
module fifo_axis_master #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [CNT_WIDTH-1:0]  o_beat_cnt,
  output logic                  o_pkt_done,
  output logic                  o_busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

  // Buffer occupancy doubles as the control state: 0, 1 or 2 words held.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_t;

  occ_t                  state, state_next;
  logic [DATA_WIDTH-1:0] head, skid;
  logic [CNT_WIDTH-1:0]  beat;
  logic                  pkt_done;
  logic                  rd;
  logic                  pop;

  // Reads are gated by reset so the pop strobe is low while rstn is asserted.
  assign rd            = rstn && i_enable && !i_fifo_empty && (state != S_TWO);
  assign m_axis_tvalid = (state != S_EMPTY);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = head;
  assign m_axis_tlast  = m_axis_tvalid && (beat == LAST_BEAT);
  assign o_fifo_rd     = rd;
  assign o_beat_cnt    = beat;
  assign o_pkt_done    = pkt_done;
  assign o_busy        = m_axis_tvalid;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_EMPTY;
    else       state <= state_next;
  end

  // Occupancy next state: +1 on read, -1 on pop, unchanged when both happen.
  always_comb begin
    state_next = state;
    case (state)
      S_EMPTY: if (rd) state_next = S_ONE;
      S_ONE: begin
        if (rd && !pop)      state_next = S_TWO;
        else if (!rd && pop) state_next = S_EMPTY;
      end
      S_TWO:   if (pop) state_next = S_ONE;
      default: state_next = S_EMPTY;
    endcase
  end

  // Head/skid buffer: new words land in the head when it is free (or being
  // popped this cycle), otherwise in the skid; the skid shifts up on pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (rd && (state == S_EMPTY || pop)) head <= i_fifo_data;
      else if (pop && state == S_TWO)      head <= skid;
      if (rd && state == S_ONE && !pop)    skid <= i_fifo_data;
    end
  end

  // Beat counter and packet-done pulse; the counter survives i_enable=0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat     <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= pop && m_axis_tlast;
      if (pop) beat <= (beat == LAST_BEAT) ? '0 : beat + CNT_WIDTH'(1);
    end
  end

`ifndef SYNTHESIS
  logic                  hold_q;
  logic [DATA_WIDTH-1:0] held_data;

  // Remember whether the previous cycle was a stalled beat and what it carried.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q    <= 1'b0;
      held_data <= '0;
    end else begin
      hold_q    <= m_axis_tvalid && !m_axis_tready;
      held_data <= head;
    end
  end

  // Protocol sanity: no pop of an empty FIFO, legal occupancy, stable stalled data.
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(rd && i_fifo_empty))
        else $fatal(1, "fifo_axis_master: FIFO read while empty");
      assert (state == S_EMPTY || state == S_ONE || state == S_TWO)
        else $fatal(1, "fifo_axis_master: occupancy above 2");
      assert (!hold_q || head == held_data)
        else $fatal(1, "fifo_axis_master: tdata changed while stalled");
    end
  end
`endif

endmodule

// File: tb/tb_fifo_axis_master.sv
// Testbench for fifo_axis_master: two instances (BURST_LEN 4 and 8) fed by
// array-based FIFO models. The reference treats the buffer as "words read but
// not yet popped" and expects the output stream to equal the FIFO word order.
module tb_fifo_axis_master;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          en     [2];
  logic          empty  [2];
  logic [DW-1:0] fdata  [2];
  logic          rd     [2];
  logic          tvalid [2];
  logic          tready [2];
  logic [DW-1:0] tdata  [2];
  logic          tlast  [2];
  logic [15:0]   cnt    [2];
  logic          done   [2];
  logic          busy   [2];

  logic [DW-1:0] fmem [2][2048];
  int            fwr [2];
  int            frd [2];
  int            optr [2];
  int            beat [2];
  logic          exp_done [2];
  int            dones [2];

  int vectors;
  int miscompares;
  int pops0;
  int rds0;

  always #5 clk = ~clk;

  fifo_axis_master #(.DATA_WIDTH(DW), .BURST_LEN(4), .CNT_WIDTH(16)) u4 (
    .clk(clk), .rstn(rstn), .i_enable(en[0]), .i_fifo_empty(empty[0]),
    .i_fifo_data(fdata[0]), .o_fifo_rd(rd[0]), .m_axis_tvalid(tvalid[0]),
    .m_axis_tready(tready[0]), .m_axis_tdata(tdata[0]), .m_axis_tlast(tlast[0]),
    .o_beat_cnt(cnt[0]), .o_pkt_done(done[0]), .o_busy(busy[0])
  );

  fifo_axis_master #(.DATA_WIDTH(DW), .BURST_LEN(8), .CNT_WIDTH(16)) u8 (
    .clk(clk), .rstn(rstn), .i_enable(en[1]), .i_fifo_empty(empty[1]),
    .i_fifo_data(fdata[1]), .o_fifo_rd(rd[1]), .m_axis_tvalid(tvalid[1]),
    .m_axis_tready(tready[1]), .m_axis_tdata(tdata[1]), .m_axis_tlast(tlast[1]),
    .o_beat_cnt(cnt[1]), .o_pkt_done(done[1]), .o_busy(busy[1])
  );

  function automatic int blen(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic [DW-1:0] w);
    fmem[d][fwr[d]] = w;
    fwr[d]++;
  endtask

  task automatic drive_fifo();
    for (int d = 0; d < 2; d++) begin
      empty[d] = (frd[d] == fwr[d]);
      fdata[d] = empty[d] ? '0 : fmem[d][frd[d]];
    end
  endtask

  // One clock cycle: present FIFO head, check every output against the model,
  // then advance the model by the reads and pops that the edge performs.
  task automatic cycle();
    bit r [2];
    bit p [2];
    bit lt [2];
    drive_fifo();
    #1;
    for (int d = 0; d < 2; d++) begin
      int occ;
      bit ev;
      occ   = frd[d] - optr[d];
      ev    = (occ != 0);
      r[d]  = en[d] && !empty[d] && (occ < 2);
      lt[d] = ev && (beat[d] == blen(d) - 1);
      p[d]  = ev && tready[d];
      chk($sformatf("d%0d_rd", d),     32'(rd[d]),     32'(r[d]));
      chk($sformatf("d%0d_tvalid", d), 32'(tvalid[d]), 32'(ev));
      chk($sformatf("d%0d_busy", d),   32'(busy[d]),   32'(ev));
      chk($sformatf("d%0d_tlast", d),  32'(tlast[d]),  32'(lt[d]));
      chk($sformatf("d%0d_beat", d),   32'(cnt[d]),    32'(beat[d]));
      chk($sformatf("d%0d_pktdone", d), 32'(done[d]),  32'(exp_done[d]));
      if (ev) chk($sformatf("d%0d_tdata", d), 32'(tdata[d]), 32'(fmem[d][optr[d]]));
      dones[d] += int'(done[d]);
    end
    pops0 += int'(tvalid[0] && tready[0]);
    rds0  += int'(rd[0]);
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (r[d]) frd[d]++;
      if (p[d]) begin
        optr[d]++;
        beat[d] = (beat[d] + 1) % blen(d);
      end
      exp_done[d] = p[d] && lt[d];
    end
  endtask

  // Assert reset between edges, check the outputs clear at once, then release.
  task automatic do_reset();
    drive_fifo();
    rstn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_tvalid", d), 32'(tvalid[d]), 0);
      chk($sformatf("d%0d_rst_busy", d),   32'(busy[d]),   0);
      chk($sformatf("d%0d_rst_beat", d),   32'(cnt[d]),    0);
      chk($sformatf("d%0d_rst_tlast", d),  32'(tlast[d]),  0);
      chk($sformatf("d%0d_rst_tdata", d),  32'(tdata[d]),  0);
      chk($sformatf("d%0d_rst_rd", d),     32'(rd[d]),     0);
      chk($sformatf("d%0d_rst_done", d),   32'(done[d]),   0);
      optr[d]     = frd[d];
      beat[d]     = 0;
      exp_done[d] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int guard;
    int pushed;
    vectors     = 0;
    miscompares = 0;
    pops0       = 0;
    rds0        = 0;
    rstn        = 1'b1;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; tready[d] = 1'b0; empty[d] = 1'b1; fdata[d] = '0;
      fwr[d] = 0; frd[d] = 0; optr[d] = 0; beat[d] = 0;
      exp_done[d] = 1'b0; dones[d] = 0;
    end
    @(negedge clk);

    // Streaming: 8 preloaded words, tready high.
    for (int i = 1; i <= 8; i++) push(0, DW'(i));
    do_reset();
    en[0] = 1'b1; en[1] = 1'b1; tready[0] = 1'b1; tready[1] = 1'b1;
    pops0 = 0; dones[0] = 0;
    repeat (10) cycle();
    chk("t1_pops", 32'(pops0), 8);
    chk("t1_pkt_done", 32'(dones[0]), 2);

    // Backpressure: tready low for 5 cycles with words waiting.
    for (int i = 0; i < 4; i++) push(0, DW'(16'h0009 + i));
    tready[0] = 1'b0; rds0 = 0;
    repeat (5) cycle();
    chk("t2_reads", 32'(rds0), 2);
    chk("t2_busy", 32'(busy[0]), 1);
    chk("t2_head", 32'(tdata[0]), 32'h0009);
    tready[0] = 1'b1;
    repeat (6) cycle();

    // Empty boundary: 3 words, then a late fourth word.
    for (int i = 0; i < 3; i++) push(0, DW'(16'h000D + i));
    repeat (4) cycle();
    chk("t3_idle_tvalid", 32'(tvalid[0]), 0);
    chk("t3_idle_beat", 32'(cnt[0]), 3);
    push(0, 16'h0010);
    cycle();
    chk("t3_late_tvalid", 32'(tvalid[0]), 1);
    chk("t3_late_tlast", 32'(tlast[0]), 1);
    repeat (3) cycle();

    // Enable gating mid-packet.
    for (int i = 0; i < 8; i++) push(0, DW'(16'h0020 + i));
    guard = 0;
    while (beat[0] != 2 && guard < 20) begin cycle(); guard++; end
    chk("t4_at_beat2", 32'(cnt[0]), 2);
    en[0] = 1'b0;
    repeat (10) cycle();
    chk("t4_drained", 32'(busy[0]), 0);
    en[0] = 1'b1;
    repeat (12) cycle();

    // Reset mid-packet with both buffer entries full.
    for (int i = 0; i < 6; i++) push(0, DW'(16'h0030 + i));
    guard = 0;
    while (beat[0] != 2 && guard < 20) begin cycle(); guard++; end
    tready[0] = 1'b0;
    repeat (2) cycle();
    chk("t5_busy", 32'(busy[0]), 1);
    chk("t5_beat", 32'(cnt[0]), 2);
    chk("t5_rd_blocked", 32'(rd[0]), 0);
    do_reset();
    tready[0] = 1'b1;
    repeat (10) cycle();

    // Randomised tready over 1000 words on the BURST_LEN=8 instance.
    pushed = 0; guard = 0; dones[1] = 0;
    while (optr[1] < 1000 && guard < 20000) begin
      if (pushed < 1000 && $urandom_range(0, 9) < 7) begin
        push(1, DW'($urandom));
        pushed++;
      end
      tready[1] = 1'($urandom_range(0, 1));
      cycle();
      guard++;
    end
    tready[1] = 1'b1;
    cycle();
    chk("t6_words_out", 32'(optr[1]), 1000);
    chk("t6_pkts", 32'(dones[1]), 125);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
